// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. It sequences
// multi-cycle flush windows after an EX-stage redirect and load-use bubbles.
// It also keeps saturating performance counters for stall cycles and
// accepted redirects.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_ni                asynchronous reset, active-low
//   id_rs1_i, id_rs2_i    source registers of the instruction in ID
//   id_uses_rs1_i/rs2_i   ID instruction actually reads rs1 / rs2
//   ex_valid_i            EX holds a real instruction (not a bubble)
//   ex_rd_i               EX destination register
//   ex_mem_read_i         EX instruction is a load
//   ex_redirect_i         EX resolved a taken branch / jal / jalr
//   ex_redirect_target_i  byte address of the redirect target
//   mem_busy_i            data memory not ready, whole pipe freezes
//   perf_clr_i            synchronous clear of the perf counters
//   pc_write_o            PC load enable
//   if_id_write_o         IF/ID load enable
//   if_id_flush_o         IF/ID loads a NOP
//   id_ex_flush_o         ID/EX loads a bubble
//   ex_mem_hold_o         EX/MEM and MEM/WB hold
//   stall_o, flush_o      any stall / any squash this cycle
//   redirect_valid_o      PC takes redirect_pc_o this cycle
//   redirect_pc_o         redirect target, passed straight through
//   stall_count_o         cycles with stall_o=1 (saturating)
//   flush_count_o         accepted redirects (saturating)

module hazard_ctrl #(
  parameter int FLUSH_CYCLES     = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_valid_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic [31:0]      ex_redirect_target_i,
  input  logic             mem_busy_i,
  input  logic             perf_clr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_hold_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int MaxCnt = (FLUSH_CYCLES > LOAD_USE_BUBBLES) ? FLUSH_CYCLES : LOAD_USE_BUBBLES;
  localparam int CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, LOAD_STALL} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              redir, hz, redir_accept;

  assign redir = ex_valid_i & ex_redirect_i;

  // A load into x0 never produces a value, so it can never cause a stall.
  assign hz = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
              ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
               (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  assign redirect_pc_o = ex_redirect_target_i;

  // Output decode and next state. Priority: memory busy, then redirect,
  // then a fresh load-use hazard, then continuation of the current window.
  always_comb begin
    pc_write_o       = 1'b1;
    if_id_write_o    = 1'b1;
    if_id_flush_o    = 1'b0;
    id_ex_flush_o    = 1'b0;
    ex_mem_hold_o    = 1'b0;
    stall_o          = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redir_accept     = 1'b0;
    state_d          = state_q;
    cnt_d            = cnt_q;

    if (!rst_ni) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (mem_busy_i) begin
      // Whole pipe frozen; EX inputs stay put, so any pending event is
      // simply re-evaluated once memory is ready.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      ex_mem_hold_o = 1'b1;
      stall_o       = 1'b1;
    end else if (redir) begin
      redirect_valid_o = 1'b1;
      if_id_flush_o    = 1'b1;
      id_ex_flush_o    = 1'b1;
      flush_o          = 1'b1;
      redir_accept     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CntW'(FLUSH_CYCLES - 1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
            stall_o       = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CntW'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
        FLUSH: begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          flush_o       = 1'b1;
          cnt_d         = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = IDLE;
        end
        LOAD_STALL: begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_flush_o = 1'b1;
          stall_o       = 1'b1;
          cnt_d         = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating perf counters; a clear beats an increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir_accept && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share the same inputs:
//   dutA: FLUSH_CYCLES=2, LOAD_USE_BUBBLES=1, CNT_W=32
//   dutB: FLUSH_CYCLES=2, LOAD_USE_BUBBLES=3, CNT_W=4 (for saturation)
// Inputs change 1ns after a rising edge; outputs are sampled mid-cycle.

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic [4:0]  idRs1, idRs2, exRd;
  logic        idUsesRs1, idUsesRs2, exValid, exMemRead, exRedirect;
  logic [31:0] exRedirectTarget;
  logic        memBusy, perfClr;

  logic        aPcWrite, aIfIdWrite, aIfIdFlush, aIdExFlush, aExMemHold;
  logic        aStall, aFlush, aRedirectValid;
  logic [31:0] aRedirectPc, aStallCount, aFlushCount;

  logic        bPcWrite, bIfIdWrite, bIfIdFlush, bIdExFlush, bExMemHold;
  logic        bStall, bFlush, bRedirectValid;
  logic [31:0] bRedirectPc;
  logic [3:0]  bStallCount, bFlushCount;

  int nCmp  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_BUBBLES(1), .CNT_W(32)) dutA (
    .clk_i(clk), .rst_ni(rstN),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_uses_rs1_i(idUsesRs1), .id_uses_rs2_i(idUsesRs2),
    .ex_valid_i(exValid), .ex_rd_i(exRd), .ex_mem_read_i(exMemRead),
    .ex_redirect_i(exRedirect), .ex_redirect_target_i(exRedirectTarget),
    .mem_busy_i(memBusy), .perf_clr_i(perfClr),
    .pc_write_o(aPcWrite), .if_id_write_o(aIfIdWrite),
    .if_id_flush_o(aIfIdFlush), .id_ex_flush_o(aIdExFlush),
    .ex_mem_hold_o(aExMemHold), .stall_o(aStall), .flush_o(aFlush),
    .redirect_valid_o(aRedirectValid), .redirect_pc_o(aRedirectPc),
    .stall_count_o(aStallCount), .flush_count_o(aFlushCount)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_BUBBLES(3), .CNT_W(4)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_uses_rs1_i(idUsesRs1), .id_uses_rs2_i(idUsesRs2),
    .ex_valid_i(exValid), .ex_rd_i(exRd), .ex_mem_read_i(exMemRead),
    .ex_redirect_i(exRedirect), .ex_redirect_target_i(exRedirectTarget),
    .mem_busy_i(memBusy), .perf_clr_i(perfClr),
    .pc_write_o(bPcWrite), .if_id_write_o(bIfIdWrite),
    .if_id_flush_o(bIfIdFlush), .id_ex_flush_o(bIdExFlush),
    .ex_mem_hold_o(bExMemHold), .stall_o(bStall), .flush_o(bFlush),
    .redirect_valid_o(bRedirectValid), .redirect_pc_o(bRedirectPc),
    .stall_count_o(bStallCount), .flush_count_o(bFlushCount)
  );

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quiet pipeline: bubble in EX, nothing read in ID.
  task automatic idleInputs();
    idRs1 = 5'd0; idRs2 = 5'd0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
    exValid = 1'b0; exRd = 5'd0; exMemRead = 1'b0; exRedirect = 1'b0;
    exRedirectTarget = 32'h0; memBusy = 1'b0; perfClr = 1'b0;
  endtask

  // lw x3,0(x1) in EX, add x4,x1,x3 in ID.
  task automatic loadUseInputs();
    idleInputs();
    exValid = 1'b1; exMemRead = 1'b1; exRd = 5'd3;
    idRs1 = 5'd1; idRs2 = 5'd3; idUsesRs1 = 1'b1; idUsesRs2 = 1'b1;
  endtask

  task automatic pulseReset();
    idleInputs();
    rstN = 1'b0;
    #3;
    rstN = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idleInputs();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h40;
    rstN = 1'b0;
    #4;
    nCmp++; if (aPcWrite !== 1'b0) begin nFail++; $display("[TB] FAIL rst_pc_write: got %b want 0", aPcWrite); end
    nCmp++; if (aIfIdWrite !== 1'b0) begin nFail++; $display("[TB] FAIL rst_if_id_write: got %b want 0", aIfIdWrite); end
    nCmp++; if (aRedirectValid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_redirect_valid: got %b want 0", aRedirectValid); end
    nCmp++; if (aFlush !== 1'b0) begin nFail++; $display("[TB] FAIL rst_flush: got %b want 0", aFlush); end
    nCmp++; if (aStallCount !== 32'd0) begin nFail++; $display("[TB] FAIL rst_stall_count: got %0d want 0", aStallCount); end
    nCmp++; if (aFlushCount !== 32'd0) begin nFail++; $display("[TB] FAIL rst_flush_count: got %0d want 0", aFlushCount); end
    step();
    idleInputs();
    rstN = 1'b1;
    #4;
    nCmp++; if (aPcWrite !== 1'b1) begin nFail++; $display("[TB] FAIL post_rst_pc_write: got %b want 1", aPcWrite); end
    nCmp++; if (aIfIdWrite !== 1'b1) begin nFail++; $display("[TB] FAIL post_rst_if_id_write: got %b want 1", aIfIdWrite); end
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL post_rst_stall: got %b want 0", aStall); end
    step();
  endtask

  task automatic test_x0();
    // lw x0 in EX, ID reads x0
    idleInputs();
    exValid = 1'b1; exMemRead = 1'b1; exRd = 5'd0;
    idRs1 = 5'd0; idUsesRs1 = 1'b1;
    #4;
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL x0_stall: got %b want 0", aStall); end
    nCmp++; if (aPcWrite !== 1'b1) begin nFail++; $display("[TB] FAIL x0_pc_write: got %b want 1", aPcWrite); end
    step();
    idleInputs();
    #4;
    nCmp++; if (aStallCount !== 32'd0) begin nFail++; $display("[TB] FAIL x0_stall_count: got %0d want 0", aStallCount); end
    step();
  endtask

  task automatic test_load_use();
    // rs2 matches but is not read: no hazard
    loadUseInputs();
    idUsesRs2 = 1'b0;
    #4;
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL lu_unused_rs2: got %b want 0", aStall); end
    // load destination matches but EX is an ALU op: ignored
    exMemRead = 1'b0; idUsesRs2 = 1'b1;
    #1;
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL lu_non_load: got %b want 0", aStall); end
    step();
    loadUseInputs();
    #4;
    nCmp++; if (aStall !== 1'b1) begin nFail++; $display("[TB] FAIL lu_stall: got %b want 1", aStall); end
    nCmp++; if (aPcWrite !== 1'b0) begin nFail++; $display("[TB] FAIL lu_pc_write: got %b want 0", aPcWrite); end
    nCmp++; if (aIfIdWrite !== 1'b0) begin nFail++; $display("[TB] FAIL lu_if_id_write: got %b want 0", aIfIdWrite); end
    nCmp++; if (aIdExFlush !== 1'b1) begin nFail++; $display("[TB] FAIL lu_id_ex_flush: got %b want 1", aIdExFlush); end
    nCmp++; if (aIfIdFlush !== 1'b0) begin nFail++; $display("[TB] FAIL lu_if_id_flush: got %b want 0", aIfIdFlush); end
    step();
    // load moved on, bubble now in EX
    exValid = 1'b0;
    #4;
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL lu_after_stall: got %b want 0", aStall); end
    nCmp++; if (aPcWrite !== 1'b1) begin nFail++; $display("[TB] FAIL lu_after_pc_write: got %b want 1", aPcWrite); end
    nCmp++; if (aStallCount !== 32'd1) begin nFail++; $display("[TB] FAIL lu_stall_count: got %0d want 1", aStallCount); end
    step();
  endtask

  task automatic test_branch();
    idleInputs();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h28;
    #4;
    nCmp++; if (aRedirectValid !== 1'b1) begin nFail++; $display("[TB] FAIL br_redirect_valid: got %b want 1", aRedirectValid); end
    nCmp++; if (aRedirectPc !== 32'h28) begin nFail++; $display("[TB] FAIL br_redirect_pc: got %h want 00000028", aRedirectPc); end
    nCmp++; if (aFlush !== 1'b1) begin nFail++; $display("[TB] FAIL br_flush0: got %b want 1", aFlush); end
    nCmp++; if ({aIfIdFlush, aIdExFlush, aPcWrite, aStall} !== 4'b1110) begin nFail++; $display("[TB] FAIL br_ctrl0: got %b want 1110", {aIfIdFlush, aIdExFlush, aPcWrite, aStall}); end
    step();
    idleInputs();
    #4;
    nCmp++; if (aFlush !== 1'b1) begin nFail++; $display("[TB] FAIL br_flush1: got %b want 1", aFlush); end
    nCmp++; if (aRedirectValid !== 1'b0) begin nFail++; $display("[TB] FAIL br_redirect_once: got %b want 0", aRedirectValid); end
    nCmp++; if ({aIfIdFlush, aIdExFlush, aPcWrite} !== 3'b111) begin nFail++; $display("[TB] FAIL br_ctrl1: got %b want 111", {aIfIdFlush, aIdExFlush, aPcWrite}); end
    nCmp++; if (aFlushCount !== 32'd1) begin nFail++; $display("[TB] FAIL br_flush_count: got %0d want 1", aFlushCount); end
    step();
    #4;
    nCmp++; if (aFlush !== 1'b0) begin nFail++; $display("[TB] FAIL br_flush_end: got %b want 0", aFlush); end
    nCmp++; if (aIfIdFlush !== 1'b0) begin nFail++; $display("[TB] FAIL br_if_id_flush_end: got %b want 0", aIfIdFlush); end
    step();
  endtask

  task automatic test_busy_hazard();
    loadUseInputs();
    memBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      nCmp++; if ({aExMemHold, aStall, aPcWrite, aIfIdWrite, aIdExFlush} !== 5'b11000) begin nFail++; $display("[TB] FAIL busy_ctrl[%0d]: got %b want 11000", i, {aExMemHold, aStall, aPcWrite, aIfIdWrite, aIdExFlush}); end
      step();
    end
    memBusy = 1'b0;
    #4;
    nCmp++; if ({aExMemHold, aStall, aIdExFlush, aPcWrite} !== 4'b0110) begin nFail++; $display("[TB] FAIL busy_then_bubble: got %b want 0110", {aExMemHold, aStall, aIdExFlush, aPcWrite}); end
    step();
    exValid = 1'b0;
    #4;
    nCmp++; if (aStall !== 1'b0) begin nFail++; $display("[TB] FAIL busy_done_stall: got %b want 0", aStall); end
    nCmp++; if (aStallCount !== 32'd5) begin nFail++; $display("[TB] FAIL busy_stall_count: got %0d want 5", aStallCount); end
    step();
  endtask

  task automatic test_busy_redirect();
    idleInputs();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h100; memBusy = 1'b1;
    #4;
    nCmp++; if ({aRedirectValid, aFlush, aExMemHold} !== 3'b001) begin nFail++; $display("[TB] FAIL busy_redir_deferred: got %b want 001", {aRedirectValid, aFlush, aExMemHold}); end
    step();
    memBusy = 1'b0;
    #4;
    nCmp++; if (aRedirectValid !== 1'b1) begin nFail++; $display("[TB] FAIL busy_redir_taken: got %b want 1", aRedirectValid); end
    nCmp++; if (aFlushCount !== 32'd1) begin nFail++; $display("[TB] FAIL busy_redir_count_held: got %0d want 1", aFlushCount); end
    step();
    idleInputs();
    #4;
    nCmp++; if (aFlush !== 1'b1) begin nFail++; $display("[TB] FAIL busy_redir_flush1: got %b want 1", aFlush); end
    nCmp++; if (aFlushCount !== 32'd2) begin nFail++; $display("[TB] FAIL busy_redir_count: got %0d want 2", aFlushCount); end
    step();
    step();
  endtask

  task automatic test_redirect_in_load_stall();
    pulseReset();
    loadUseInputs();
    #4;
    nCmp++; if (bStall !== 1'b1) begin nFail++; $display("[TB] FAIL ls_bubble0: got %b want 1", bStall); end
    step();
    #4;
    nCmp++; if ({bStall, bIdExFlush, bPcWrite} !== 3'b110) begin nFail++; $display("[TB] FAIL ls_bubble1: got %b want 110", {bStall, bIdExFlush, bPcWrite}); end
    step();
    // jalr resolves while the third bubble is due
    idleInputs();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h80;
    #4;
    nCmp++; if ({bRedirectValid, bFlush, bStall, bPcWrite} !== 4'b1101) begin nFail++; $display("[TB] FAIL ls_redirect_wins: got %b want 1101", {bRedirectValid, bFlush, bStall, bPcWrite}); end
    nCmp++; if (bRedirectPc !== 32'h80) begin nFail++; $display("[TB] FAIL ls_redirect_pc: got %h want 00000080", bRedirectPc); end
    step();
    idleInputs();
    #4;
    nCmp++; if ({bFlush, bRedirectValid, bStall} !== 3'b100) begin nFail++; $display("[TB] FAIL ls_in_flush: got %b want 100", {bFlush, bRedirectValid, bStall}); end
    nCmp++; if (bFlushCount !== 4'd1) begin nFail++; $display("[TB] FAIL ls_flush_count: got %0d want 1", bFlushCount); end
    nCmp++; if (bStallCount !== 4'd2) begin nFail++; $display("[TB] FAIL ls_stall_count: got %0d want 2", bStallCount); end
    step();
    #4;
    nCmp++; if ({bFlush, bStall, bPcWrite} !== 3'b001) begin nFail++; $display("[TB] FAIL ls_idle: got %b want 001", {bFlush, bStall, bPcWrite}); end
    step();
  endtask

  task automatic test_reset_mid_flush();
    pulseReset();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h28;
    step();
    idleInputs();
    #2;
    nCmp++; if (aFlush !== 1'b1) begin nFail++; $display("[TB] FAIL mid_flush_active: got %b want 1", aFlush); end
    rstN = 1'b0;
    #1;
    nCmp++; if ({aFlush, aIfIdFlush, aPcWrite} !== 3'b000) begin nFail++; $display("[TB] FAIL mid_flush_rst_ctrl: got %b want 000", {aFlush, aIfIdFlush, aPcWrite}); end
    nCmp++; if (aFlushCount !== 32'd0) begin nFail++; $display("[TB] FAIL mid_flush_rst_count: got %0d want 0", aFlushCount); end
    step();
    rstN = 1'b1;
    #3;
    nCmp++; if ({aPcWrite, aFlush} !== 2'b10) begin nFail++; $display("[TB] FAIL mid_flush_release: got %b want 10", {aPcWrite, aFlush}); end
    step();
  endtask

  task automatic test_saturation();
    pulseReset();
    memBusy = 1'b1;
    for (int i = 0; i < 17; i++) step();
    memBusy = 1'b0;
    #4;
    nCmp++; if (bStallCount !== 4'd15) begin nFail++; $display("[TB] FAIL sat_stall_count: got %0d want 15", bStallCount); end
    nCmp++; if (aStallCount !== 32'd17) begin nFail++; $display("[TB] FAIL wide_stall_count: got %0d want 17", aStallCount); end
    step();
    exValid = 1'b1; exRedirect = 1'b1; exRedirectTarget = 32'h4;
    for (int i = 0; i < 17; i++) step();
    #4;
    nCmp++; if (bFlushCount !== 4'd15) begin nFail++; $display("[TB] FAIL sat_flush_count: got %0d want 15", bFlushCount); end
    nCmp++; if (aFlushCount !== 32'd17) begin nFail++; $display("[TB] FAIL wide_flush_count: got %0d want 17", aFlushCount); end
    // clear with a redirect still being accepted this cycle
    perfClr = 1'b1;
    step();
    idleInputs();
    #4;
    nCmp++; if (bFlushCount !== 4'd0) begin nFail++; $display("[TB] FAIL clr_flush_count: got %0d want 0", bFlushCount); end
    nCmp++; if (bStallCount !== 4'd0) begin nFail++; $display("[TB] FAIL clr_stall_count: got %0d want 0", bStallCount); end
    nCmp++; if (aFlushCount !== 32'd0) begin nFail++; $display("[TB] FAIL clr_wide_flush_count: got %0d want 0", aFlushCount); end
    step();
  endtask

  initial begin
    idleInputs();
    rstN = 1'b0;
    test_reset();
    test_x0();
    test_load_use();
    test_branch();
    test_busy_hazard();
    test_busy_redirect();
    test_redirect_in_load_stall();
    test_reset_mid_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined core; it produces the `stall`, `flush` and per-register write/flush enables that the pipeline registers consume.
- Inputs: ID-stage source operands, ID/EX destination and load flag, EX-stage redirect (taken branch, jal, jalr) and data-memory busy.
- Small FSM plus counters: sequences multi-cycle flush windows and load-use bubbles, and keeps saturating performance counters for stall and flush events.

Parameters:
FLUSH_CYCLES, 2, cycles of IF/ID+ID/EX squash per accepted redirect (>=1)
LOAD_USE_BUBBLES, 1, stall cycles inserted per load-use hazard (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_rd  in  5  EX destination register
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/jal/jalr
ex_redirect_target  in  32  byte address of redirect target
mem_busy  in  1  data memory not ready; whole pipe must freeze
perf_clr  in  1  synchronous clear of perf counters
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads NOP (addi x0,x0,0)
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_hold  out  1  EX/MEM and MEM/WB hold
stall  out  1  any stall this cycle
flush  out  1  any squash this cycle
redirect_valid  out  1  PC takes redirect_pc this cycle
redirect_pc  out  32  = ex_redirect_target (combinational)
stall_count  out  CNT_W  cycles with stall=1
flush_count  out  CNT_W  accepted redirects

Behaviour:
- Registers: state {IDLE, FLUSH, LOAD_STALL}, down-counter cnt, stall_count, flush_count. Outputs are combinational from state and inputs.
- rst low, asynchronous: state=IDLE, cnt=0, counters=0. While rst is low: pc_write=0, if_id_write=0; all flush/stall/hold/redirect_valid=0.
- Defaults (no event): pc_write=1, if_id_write=1; others 0.
- redir = ex_valid & ex_redirect.
- hz = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority each cycle: mem_busy > redir > hz > state continuation.
- mem_busy=1, any state:
  - pc_write=0, if_id_write=0, ex_mem_hold=1, stall=1; no flush/redirect.
  - state and cnt hold.
  - A pending redirect or hazard is deferred: inputs stay stable because EX is frozen.
- redir, not busy, any state:
  - redirect_valid=1, if_id_flush=1, id_ex_flush=1, flush=1, pc_write=1.
  - flush_count++.
  - If FLUSH_CYCLES>1: cnt=FLUSH_CYCLES-1, go FLUSH; else IDLE.
  - Redirect aborts any LOAD_STALL in progress.
- hz in IDLE, not busy, no redir:
  - pc_write=0, if_id_write=0, id_ex_flush=1, stall=1.
  - If LOAD_USE_BUBBLES>1: cnt=LOAD_USE_BUBBLES-1, go LOAD_STALL.
- FLUSH:
  - if_id_flush=1, id_ex_flush=1, flush=1, redirect_valid=0, pc_write=1.
  - cnt--; go IDLE when cnt reaches 0, i.e. on the cycle cnt==1 transitions.
- LOAD_STALL: same outputs as hz; cnt--; go IDLE when cnt reaches 0.
- Latency: redirect is visible same cycle; the first correct-path instruction reaches ID FLUSH_CYCLES+1 cycles after the redirect cycle.
- Perf counters:
  - stall_count increments every cycle stall=1.
  - Both counters saturate at 2^CNT_W-1.
  - perf_clr sets both to 0 and takes priority over an increment in the same cycle.
- ex_rd==0 never causes a stall.
- The block does not forward; non-load RAW hazards are ignored.

Test Plan:
- lw x3,0(x1) in EX, add x4,x1,x3 in ID -> exactly 1 cycle: stall=1, pc_write=0, id_ex_flush=1; stall_count=1; next cycle defaults.
- beq x1,x1 at PC 28 taken, target 0x28 -> redirect_valid=1, redirect_pc=0x28 for 1 cycle; flush=1 for 2 cycles (FLUSH_CYCLES=2); flush_count=1; addi x6/x7 never written.
- Load-use hazard with mem_busy=1 for 3 cycles -> ex_mem_hold=1 and state held for 3 cycles, then 1 load-use bubble; stall_count=4.
- lw x0 in EX, ID reads x0 -> no stall; stall_count stays 0.
- jalr redirect while in LOAD_STALL (LOAD_USE_BUBBLES=3) -> redirect wins that cycle; state enters FLUSH; flush_count increments.
- rst low asserted mid-FLUSH -> immediately state IDLE, counters 0, flush=0; after release pc_write=1. Separately, preload counter at max -> stays at max; perf_clr -> 0.
